// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job arbiter slice: FSM state encoding and
// default sizing constants used by the arbiter, its interface and sub-blocks.
package gcd_pkg;

    localparam int GCD_WIDTH_DEFAULT = 16;
    localparam int GCD_NREQ_MAX      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } gcd_arb_state_t;

endpackage

// File: rtl/gcd_job_arbiter_if.sv
// Bundle of requester, engine and response signals around gcd_job_arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface gcd_job_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = gcd_pkg::GCD_WIDTH_DEFAULT,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   eng_go;
    logic [WIDTH-1:0]       eng_a;
    logic [WIDTH-1:0]       eng_b;
    logic                   eng_done;
    logic [WIDTH-1:0]       eng_result;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic                   busy;

    modport slave (
        input  req_valid, req_a, req_b, eng_done, eng_result, rsp_ready,
        output req_ready, eng_go, eng_a, eng_b, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, eng_done, eng_result, rsp_ready,
        input  req_ready, eng_go, eng_a, eng_b, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/gcd_rr_arbiter.sv
// Purely combinational round-robin picker: scans req_valid starting at
// rr_ptr and returns the first pending requester as one-hot and index.
module gcd_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    // Walk the requesters in priority order rr_ptr, rr_ptr+1, ... (wrapping).
    // rr_ptr and the offset are both below N_REQ, so one subtraction wraps.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (en && !found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end
endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one GCD engine among N_REQ requesters: round-robin job pick,
// operand capture, engine start pulse, result return on a valid/ready port.
// Optional feature macro: GCD_ARB_ZERO_BYPASS_EN -- jobs with a zero operand
// are answered directly (gcd(0,x)=x) without starting the engine.
module gcd_job_arbiter
    import gcd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = GCD_WIDTH_DEFAULT,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    gcd_job_arbiter_if.slave bus
);
    localparam logic [1:0]      ST_IDLE  = IDLE;
    localparam logic [1:0]      ST_ISSUE = ISSUE;
    localparam logic [1:0]      ST_WAIT  = WAIT;
    localparam logic [1:0]      ST_RESP  = RESP;
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

    logic [1:0]       state_q,  state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] op_a_q,   op_a_d;
    logic [WIDTH-1:0] op_b_q,   op_b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;

    logic             arb_en;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             zero_job;

    // Grants only in IDLE; held off while reset is asserted so req_ready
    // reads zero during reset even with requests pending.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    gcd_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    // One-hot AND-OR mux of the granted requester's operands.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | bus.req_a[i*WIDTH +: WIDTH];
                sel_b = sel_b | bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef GCD_ARB_ZERO_BYPASS_EN
    assign zero_job = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_job = 1'b0;
`endif

    // Next-state and capture logic for the IDLE/ISSUE/WAIT/RESP job cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        cur_id_d = cur_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    cur_id_d = grant_id;
                    rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    if (zero_job) begin
                        res_d   = sel_a | sel_b;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.eng_done) begin
                    res_d   = bus.eng_result;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight job immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            cur_id_q <= cur_id_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.eng_go    = (state_q == ST_ISSUE);
    assign bus.eng_a     = op_a_q;
    assign bus.eng_b     = op_b_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = cur_id_q;
    assign bus.rsp_data  = res_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Randomized bench for gcd_job_arbiter. The bench plays the requesters, the
// GCD engine and the response consumer; expectations come from a plain
// round-robin pick over pending requesters and Euclid's algorithm.
module tb_gcd_job_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_job_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    gcd_job_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] ta  [N];
    logic [W-1:0] tbo [N];
    logic [N-1:0] vmask;
    int           rr_m = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // First pending requester at or after pointer p, wrapping; -1 if none.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = ta[i];
            bus.req_b[i*W +: W] = tbo[i];
        end
        bus.req_valid = vmask;
    endtask

    // Called at a falling edge with the DUT in IDLE; returns at a falling
    // edge with the DUT back in IDLE.
    task automatic run_job(input int done_dly, input int bp, output int w);
        int           g;
        bit           bypass;
        logic [W-1:0] ga, gb;
        drive_reqs();
        #1;
        w = pick(vmask, rr_m);
        if (w < 0) begin
            check_eq("idle_no_grant", 32'(bus.req_ready), 0);
            check_eq("idle_busy", 32'(bus.busy), 0);
            @(negedge clk);
            return;
        end
        check_eq("grant_onehot", 32'(bus.req_ready), 32'(1) << w);
        check_eq("idle_busy", 32'(bus.busy), 0);
        ga = ta[w];
        gb = tbo[w];
        g  = gcd_ref(int'(ga), int'(gb));
        bypass = 1'b0;
`ifdef GCD_ARB_ZERO_BYPASS_EN
        bypass = (ga == '0) || (gb == '0);
`endif
        rr_m = (w + 1) % N;
        @(negedge clk);
        if (!bypass) begin
            check_eq("issue_go", 32'(bus.eng_go), 1);
            check_eq("issue_eng_a", 32'(bus.eng_a), 32'(ga));
            check_eq("issue_eng_b", 32'(bus.eng_b), 32'(gb));
            check_eq("issue_busy", 32'(bus.busy), 1);
            check_eq("issue_no_ready", 32'(bus.req_ready), 0);
            // Granted job is consumed; scribbling its inputs must not matter.
            vmask[w] = 1'b0;
            ta[w]    = W'($urandom);
            tbo[w]   = W'($urandom);
            drive_reqs();
            if ($urandom_range(0, 1) == 1) begin
                bus.eng_done   = 1'b1;
                bus.eng_result = W'($urandom);
            end
            @(negedge clk);
            bus.eng_done = 1'b0;
            check_eq("go_single_cycle", 32'(bus.eng_go), 0);
            check_eq("wait_no_rsp", 32'(bus.rsp_valid), 0);
            check_eq("wait_eng_a_stable", 32'(bus.eng_a), 32'(ga));
            check_eq("wait_eng_b_stable", 32'(bus.eng_b), 32'(gb));
            for (int d = 0; d < done_dly; d++) begin
                @(negedge clk);
                check_eq("wait_no_rsp", 32'(bus.rsp_valid), 0);
                check_eq("wait_no_go", 32'(bus.eng_go), 0);
            end
            bus.eng_done   = 1'b1;
            bus.eng_result = W'(g);
            @(negedge clk);
            bus.eng_done = 1'b0;
        end else begin
            check_eq("bypass_no_go", 32'(bus.eng_go), 0);
            vmask[w] = 1'b0;
            drive_reqs();
        end
        check_eq("rsp_valid", 32'(bus.rsp_valid), 1);
        check_eq("rsp_id", 32'(bus.rsp_id), w);
        check_eq("rsp_data", 32'(bus.rsp_data), g);
        check_eq("rsp_no_go", 32'(bus.eng_go), 0);
        for (int c = 0; c < bp; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.eng_done   = 1'b1;
                bus.eng_result = W'($urandom);
            end
            @(negedge clk);
            bus.eng_done = 1'b0;
            check_eq("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            check_eq("bp_rsp_data", 32'(bus.rsp_data), g);
            check_eq("bp_rsp_id", 32'(bus.rsp_id), w);
            check_eq("bp_no_ready", 32'(bus.req_ready), 0);
            check_eq("bp_no_go", 32'(bus.eng_go), 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_eq("done_rsp_clear", 32'(bus.rsp_valid), 0);
        check_eq("done_idle", 32'(bus.busy), 0);
        $display("[TB] job id=%0d a=%0d b=%0d gcd=%0d bp=%0d", w, ga, gb, g, bp);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           w;
        logic [N-1:0] arr;
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        bus.rsp_ready  = 1'b0;
        for (int i = 0; i < N; i++) begin
            ta[i]  = '0;
            tbo[i] = '0;
        end

        // Reset state, with requests pending to show req_ready held low.
        vmask = '1;
        drive_reqs();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_req_ready", 32'(bus.req_ready), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_eng_go", 32'(bus.eng_go), 0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_eng_a", 32'(bus.eng_a), 0);
        check_eq("rst_eng_b", 32'(bus.eng_b), 0);
        check_eq("rst_rsp_id", 32'(bus.rsp_id), 0);
        check_eq("rst_rsp_data", 32'(bus.rsp_data), 0);
        vmask = '0;
        drive_reqs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin order with all four pending.
        ta[0] = 12;  tbo[0] = 8;
        ta[1] = 35;  tbo[1] = 14;
        ta[2] = 27;  tbo[2] = 18;
        ta[3] = 100; tbo[3] = 75;
        vmask = '1;
        for (int k = 0; k < N; k++) begin
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), w);
            check_eq("rr_order", w, k);
        end

        // Single job on requester 2 with 5 cycles of backpressure.
        ta[2] = 48; tbo[2] = 18;
        vmask = 4'b0100;
        run_job(3, 5, w);
        check_eq("single_id", w, 2);

        // Pointer advance: after requester 1, requester 3 beats requester 0.
        ta[1] = 9; tbo[1] = 6;
        vmask = 4'b0010;
        run_job(0, 0, w);
        ta[0] = 64; tbo[0] = 40;
        ta[3] = 81; tbo[3] = 54;
        vmask = 4'b1001;
        run_job(1, 0, w);
        check_eq("ptr_advance", w, 3);
        run_job(0, 1, w);
        check_eq("ptr_advance_next", w, 0);

        // Zero operand job.
        ta[1] = 0; tbo[1] = 21;
        vmask = 4'b0010;
        run_job(2, 1, w);

        // Randomized arrivals, withdrawals, engine latency and backpressure.
        for (int it = 0; it < 40; it++) begin
            arr = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (arr[i] && !vmask[i]) begin
                    vmask[i] = 1'b1;
                    ta[i]    = W'($urandom_range(1, 1000));
                    tbo[i]   = W'($urandom_range(1, 1000));
                end
            end
            if ($urandom_range(0, 4) == 0) vmask = vmask & N'($urandom);
            if ($urandom_range(0, 9) == 0) vmask = '0;
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), w);
        end

        // Reset while the engine is running; spurious done afterwards.
        vmask = '0;
        drive_reqs();
        @(negedge clk);
        ta[2] = 30; tbo[2] = 12;
        vmask = 4'b0100;
        drive_reqs();
        @(negedge clk);
        check_eq("mid_issue_go", 32'(bus.eng_go), 1);
        vmask = '0;
        drive_reqs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(bus.busy), 0);
        check_eq("midrst_eng_a", 32'(bus.eng_a), 0);
        check_eq("midrst_eng_b", 32'(bus.eng_b), 0);
        check_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("midrst_rsp_id", 32'(bus.rsp_id), 0);
        @(negedge clk);
        rst  = 1'b0;
        rr_m = 0;
        @(negedge clk);
        bus.eng_done   = 1'b1;
        bus.eng_result = 16'd99;
        @(negedge clk);
        bus.eng_done = 1'b0;
        check_eq("spurious_done_rsp", 32'(bus.rsp_valid), 0);
        check_eq("spurious_done_busy", 32'(bus.busy), 0);
        ta[1] = 20; tbo[1] = 15;
        ta[3] = 7;  tbo[3] = 21;
        vmask = 4'b1010;
        run_job(1, 0, w);
        check_eq("ptr_after_reset", w, 1);
        $display("[TB] reset mid-job recovered, next grant id=%0d", w);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_job_arbiter.md
# gcd_job_arbiter

Shares one GCD engine (controller plus datapath) among `N_REQ` independent requesters. The block does four things:
- Selects one pending job by round-robin.
- Captures its operands and pulses the engine's `go`.
- Waits for the engine's `done`.
- Returns the result, tagged with the requester index, over a valid/ready response port.

It sits between the requester fabric and the single GCD engine instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 16: operand and result width in bits.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  `N_REQ`  per-requester job pending.
- `req_ready`  out  `N_REQ`  per-requester job accepted this cycle; one-hot or zero.
- `req_a`  in  `N_REQ*WIDTH`  operand A; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `req_b`  in  `N_REQ*WIDTH`  operand B; same packing as `req_a`.
- `eng_go`  out  1  one-cycle start pulse to the engine.
- `eng_a`  out  `WIDTH`  operand A to the engine.
- `eng_b`  out  `WIDTH`  operand B to the engine.
- `eng_done`  in  1  engine finished; one-cycle pulse.
- `eng_result`  in  `WIDTH`  engine result; valid while `eng_done` is high.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  `ID_W`  index of the requester that owns the result.
- `rsp_data`  out  `WIDTH`  GCD result.
- `busy`  out  1  high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Combinational round-robin search over `req_valid`, starting at pointer `rr_ptr`.
  - If a winner g exists: `req_ready[g]=1`, `req_a[g]`/`req_b[g]` are captured into `op_a`/`op_b`, g is captured into `cur_id`, and `rr_ptr` becomes (g+1) mod `N_REQ`. Next state is ISSUE.
  - Otherwise stay in IDLE with `req_ready=0`.
- **ISSUE**
  - `eng_go=1` for exactly this one cycle. Next state is WAIT.
- **WAIT**
  - Hold until `eng_done=1`. On that cycle `eng_result` is captured into `res`; next state is RESP.
- **RESP**
  - `rsp_valid=1`, `rsp_id=cur_id`, `rsp_data=res`, all held stable until `rsp_ready=1`. Next state is IDLE.
- `eng_a`/`eng_b` are driven from `op_a`/`op_b` and stay stable from ISSUE through the end of WAIT.
- `eng_done` is ignored in every state except WAIT.
- A requester may deassert `req_valid` before it is granted; it is then simply skipped. Once a requester is granted, later changes on its request inputs have no effect.
- `req_ready` is a combinational function of `req_valid` and `rr_ptr`, and is zero outside IDLE.
- `rr_ptr` changes only on acceptance. A lone requester may be granted back-to-back.
- Requesters that are waiting are never starved: grant distance is at most `N_REQ` jobs.

## Timing
- Reset values: state=IDLE; `rr_ptr`, `op_a`, `op_b`, `res`, `cur_id` = 0; `req_ready`, `eng_go`, `rsp_valid`, `busy` = 0; `eng_a`, `eng_b`, `rsp_id`, `rsp_data` = 0.
- Cycle sequence for one job:
  - Accept edge at T.
  - `eng_go` high during cycle T+1.
  - `eng_done` sampled at edge D, where D ≥ T+2.
  - `rsp_valid` high from D+1.
  - If `rsp_ready` is high at that edge, the block is back in IDLE at D+2.
- Minimum arbiter overhead is 3 cycles per job, excluding engine time.
- If `rsp_ready` is held low, the response is held indefinitely and no new job is accepted.
- Reset asserted in any state (including WAIT with the engine running) returns the block to its reset values immediately; the in-flight job is discarded. The engine shares `rst` and aborts with it.

## Configuration
- Macro: `GCD_ARB_ZERO_BYPASS_EN`.
- **Defined:** in IDLE, if a granted job has `op_a==0` or `op_b==0`, the engine is not started.
  - Next state is RESP directly, with `res = op_a | op_b`, so gcd(0,x)=x and gcd(0,0)=0.
  - `eng_go` stays 0 for that job; latency is accept edge → `rsp_valid` next cycle.
- **Undefined:** zero operands are dispatched unchanged. The subtractive engine does not terminate on them, so callers must never issue zero.

## Structure
- Shared package `gcd_pkg` contains:
  - the state enum `gcd_arb_state_t` (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - `GCD_WIDTH_DEFAULT=16`;
  - `GCD_NREQ_MAX=16`.
- Sub-module `gcd_rr_arbiter`, parameterised by `N_REQ`:
  - inputs: `req_valid`, `rr_ptr`, `en`;
  - outputs: one-hot `grant` and the encoded `grant_id`;
  - purely combinational.
- The pointer register and FSM live in `gcd_job_arbiter`.

## Test plan
- **Single job:** requester 2 sends A=48, B=18 → `eng_go` one cycle after accept; after `eng_done` with result 6, `rsp_valid` with `rsp_id=2`, `rsp_data=6`.
- **Round-robin order:** all four requesters valid from reset, jobs (12,8), (35,14), (27,18), (100,75) → grant order 0,1,2,3; results 4, 7, 9, 25.
- **Pointer advance:** after serving requester 1, requesters 0 and 3 are valid → requester 3 is granted before requester 0.
- **Backpressure:** `rsp_ready` low for 5 cycles on result 6 → `rsp_valid`/`rsp_data` stable, `req_ready` stays 0, `eng_go` stays 0 throughout.
- **Zero operands:** job (0,21) with `GCD_ARB_ZERO_BYPASS_EN` → `rsp_data=21` one cycle after accept, `eng_go` never asserted. Without the macro → `eng_go` pulses once with `eng_a=0`, `eng_b=21`.
- **Reset mid-job:** `rst` pulsed during WAIT → all outputs 0 and `rr_ptr=0`; a spurious `eng_done` one cycle after reset release produces no `rsp_valid`.
